// File: rtl/e203_lsu_icb_arbt.sv
// Round-robin ICB arbiter that merges the AGU and NICE command channels into one LSU channel
// and steers in-order responses back through a FIFO of outstanding requester IDs.
module e203_lsu_icb_arbt #(
   parameter int OUTS_DEPTH = 2,
   parameter int CNT_W      = $clog2(OUTS_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             nice_mem_holdup,

   input  logic             agu_icb_cmd_valid,
   output logic             agu_icb_cmd_ready,
   input  logic [31:0]      agu_icb_cmd_addr,
   input  logic             agu_icb_cmd_read,
   input  logic [31:0]      agu_icb_cmd_wdata,
   input  logic [3:0]       agu_icb_cmd_wmask,
   input  logic [1:0]       agu_icb_cmd_size,
   output logic             agu_icb_rsp_valid,
   input  logic             agu_icb_rsp_ready,
   output logic             agu_icb_rsp_err,
   output logic [31:0]      agu_icb_rsp_rdata,

   input  logic             nice_icb_cmd_valid,
   output logic             nice_icb_cmd_ready,
   input  logic [31:0]      nice_icb_cmd_addr,
   input  logic             nice_icb_cmd_read,
   input  logic [31:0]      nice_icb_cmd_wdata,
   input  logic [3:0]       nice_icb_cmd_wmask,
   input  logic [1:0]       nice_icb_cmd_size,
   output logic             nice_icb_rsp_valid,
   input  logic             nice_icb_rsp_ready,
   output logic             nice_icb_rsp_err,
   output logic [31:0]      nice_icb_rsp_rdata,

   output logic             o_icb_cmd_valid,
   input  logic             o_icb_cmd_ready,
   output logic [31:0]      o_icb_cmd_addr,
   output logic             o_icb_cmd_read,
   output logic [31:0]      o_icb_cmd_wdata,
   output logic [3:0]       o_icb_cmd_wmask,
   output logic [1:0]       o_icb_cmd_size,
   input  logic             o_icb_rsp_valid,
   output logic             o_icb_rsp_ready,
   input  logic             o_icb_rsp_err,
   input  logic [31:0]      o_icb_rsp_rdata,

   output logic [CNT_W-1:0] arb_outs_cnt,
   output logic             arb_spur_rsp
);

   localparam int               PTR_W    = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUTS_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTS_DEPTH - 1);

   logic                  lastGnt_q, lastGnt_d;
   logic [OUTS_DEPTH-1:0] idFifo_q, idFifo_d;
   logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  spur_q, spur_d;

   logic fifoFull, fifoEmpty;
   logic aguElig, niceElig, selNice;
   logic cmdHs, rspHs, headId;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign fifoFull  = (cnt_q == DEPTH_C);
   assign fifoEmpty = (cnt_q == '0);
   assign aguElig   = agu_icb_cmd_valid & ~nice_mem_holdup;
   assign niceElig  = nice_icb_cmd_valid;
   // On contention the requester not granted last wins; lastGnt_q=1 means NICE went last.
   assign selNice   = niceElig & (~aguElig | ~lastGnt_q);
   assign headId    = idFifo_q[rdPtr_q];

   assign o_icb_cmd_valid    = rst_n & (aguElig | niceElig) & ~fifoFull;
   assign agu_icb_cmd_ready  = rst_n & ~selNice & ~nice_mem_holdup & o_icb_cmd_ready & ~fifoFull;
   assign nice_icb_cmd_ready = rst_n & selNice & o_icb_cmd_ready & ~fifoFull;
   assign o_icb_cmd_addr     = selNice ? nice_icb_cmd_addr  : agu_icb_cmd_addr;
   assign o_icb_cmd_read     = selNice ? nice_icb_cmd_read  : agu_icb_cmd_read;
   assign o_icb_cmd_wdata    = selNice ? nice_icb_cmd_wdata : agu_icb_cmd_wdata;
   assign o_icb_cmd_wmask    = selNice ? nice_icb_cmd_wmask : agu_icb_cmd_wmask;
   assign o_icb_cmd_size     = selNice ? nice_icb_cmd_size  : agu_icb_cmd_size;

   // An empty FIFO swallows any stray response so the downstream never stalls on it.
   assign o_icb_rsp_ready    = rst_n & (fifoEmpty | (headId ? nice_icb_rsp_ready : agu_icb_rsp_ready));
   assign agu_icb_rsp_valid  = rst_n & ~fifoEmpty & ~headId & o_icb_rsp_valid;
   assign nice_icb_rsp_valid = rst_n & ~fifoEmpty & headId & o_icb_rsp_valid;
   assign agu_icb_rsp_err    = o_icb_rsp_err;
   assign agu_icb_rsp_rdata  = o_icb_rsp_rdata;
   assign nice_icb_rsp_err   = o_icb_rsp_err;
   assign nice_icb_rsp_rdata = o_icb_rsp_rdata;

   assign cmdHs = o_icb_cmd_valid & o_icb_cmd_ready;
   assign rspHs = o_icb_rsp_valid & o_icb_rsp_ready & ~fifoEmpty;

   assign arb_outs_cnt = cnt_q;
   assign arb_spur_rsp = spur_q;

   always_comb begin
      lastGnt_d = lastGnt_q;
      idFifo_d  = idFifo_q;
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      cnt_d     = cnt_q;
      spur_d    = rst_n & o_icb_rsp_valid & fifoEmpty;
      if (cmdHs) begin
         idFifo_d[wrPtr_q] = selNice;
         wrPtr_d           = nextPtr(wrPtr_q);
         lastGnt_d         = selNice;
      end
      if (rspHs) begin
         rdPtr_d = nextPtr(rdPtr_q);
      end
      case ({cmdHs, rspHs})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lastGnt_q <= 1'b1;
         idFifo_q  <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         cnt_q     <= '0;
         spur_q    <= 1'b0;
      end else begin
         lastGnt_q <= lastGnt_d;
         idFifo_q  <= idFifo_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         cnt_q     <= cnt_d;
         spur_q    <= spur_d;
      end
   end

endmodule
